// File: rtl/div_unit_if.sv
// Operand/result handshake between the issue logic and the iterative divider.
// The master side launches operations and flushes them; the slave side is the
// divider itself.
interface div_unit_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        kill_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output start_i,
    output op_i,
    output a_i,
    output b_i,
    output kill_i,
    input  busy_o,
    input  done_o,
    input  result_o
  );

  modport slave (
    input  start_i,
    input  op_i,
    input  a_i,
    input  b_i,
    input  kill_i,
    output busy_o,
    output done_o,
    output result_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes, sign fix-up in a final cycle.
// Divide-by-zero and signed overflow bypass the iterations entirely.
module div_unit (
  input  logic       clk_i,
  input  logic       rst_i,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic        load_s;
  logic        step_s;
  logic        fix_s;

  logic [1:0]  op_r;
  logic        neg_quo_r;
  logic        neg_rem_r;
  logic [31:0] div_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [5:0]  cnt_r;
  logic        spec_r;
  logic [31:0] spec_res_r;
  logic [31:0] result_r;
  logic        done_r;

  logic        signed_op_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic        div_zero_s;
  logic        ovf_s;
  logic        special_s;
  logic [31:0] special_res_s;
  logic [32:0] shifted_s;
  logic        fits_s;
  logic [31:0] diff_s;
  logic [31:0] fix_res_s;

  // Two's complement negation, modulo 2^32.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  assign signed_op_s = ~bus.op_i[0];
  assign abs_a_s     = (signed_op_s && bus.a_i[31]) ? neg32(bus.a_i) : bus.a_i;
  assign abs_b_s     = (signed_op_s && bus.b_i[31]) ? neg32(bus.b_i) : bus.b_i;
  assign div_zero_s  = (bus.b_i == 32'h0000_0000);
  assign ovf_s       = signed_op_s && (bus.a_i == 32'h8000_0000) && (bus.b_i == 32'hFFFF_FFFF);
  assign special_s   = div_zero_s || ovf_s;

  // The shift keeps rem_r[31] so divisors of 2^31 and above still compare correctly;
  // the difference always fits in 32 bits whenever it is taken.
  assign shifted_s   = {rem_r, quo_r[31]};
  assign fits_s      = (shifted_s >= {1'b0, div_r});
  assign diff_s      = shifted_s[31:0] - div_r;

  // Preloaded result for the cases that skip the iterations.
  always_comb begin
    special_res_s = 32'h0000_0000;
    if (div_zero_s) begin
      special_res_s = bus.op_i[1] ? bus.a_i : 32'hFFFF_FFFF;
    end else if (ovf_s) begin
      special_res_s = bus.op_i[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      special_res_s = 32'h0000_0000;
    end
  end

  // Sign correction of the iterated quotient/remainder.
  always_comb begin
    fix_res_s = 32'h0000_0000;
    case (op_r)
      2'b00:   fix_res_s = neg_quo_r ? neg32(quo_r) : quo_r;
      2'b01:   fix_res_s = quo_r;
      2'b10:   fix_res_s = neg_rem_r ? neg32(rem_r) : rem_r;
      2'b11:   fix_res_s = rem_r;
      default: fix_res_s = rem_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and datapath control; kill overrides everything, including a start.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    fix_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.kill_i) begin
          state_nx_s = IDLE;
        end else if (bus.start_i) begin
          load_s     = 1'b1;
          state_nx_s = special_s ? FIX : CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (bus.kill_i) begin
          state_nx_s = IDLE;
        end else begin
          step_s     = 1'b1;
          state_nx_s = (cnt_r == 6'd31) ? FIX : CALC;
        end
      end
      FIX: begin
        if (bus.kill_i) begin
          state_nx_s = IDLE;
        end else begin
          fix_s      = 1'b1;
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Operand capture, shift/subtract iterations and the output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_r       <= 2'b00;
      neg_quo_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_r      <= 32'h0000_0000;
      quo_r      <= 32'h0000_0000;
      rem_r      <= 32'h0000_0000;
      cnt_r      <= 6'd0;
      spec_r     <= 1'b0;
      spec_res_r <= 32'h0000_0000;
      result_r   <= 32'h0000_0000;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load_s) begin
        op_r       <= bus.op_i;
        neg_quo_r  <= signed_op_s & (bus.a_i[31] ^ bus.b_i[31]);
        neg_rem_r  <= signed_op_s & bus.a_i[31];
        div_r      <= abs_b_s;
        quo_r      <= abs_a_s;
        rem_r      <= 32'h0000_0000;
        cnt_r      <= 6'd0;
        spec_r     <= special_s;
        spec_res_r <= special_res_s;
      end else if (step_s) begin
        if (fits_s) begin
          rem_r <= diff_s;
          quo_r <= {quo_r[30:0], 1'b1};
        end else begin
          rem_r <= shifted_s[31:0];
          quo_r <= {quo_r[30:0], 1'b0};
        end
        cnt_r <= cnt_r + 6'd1;
      end else if (fix_s) begin
        result_r <= spec_r ? spec_res_r : fix_res_s;
        done_r   <= 1'b1;
      end
    end
  end

  assign bus.busy_o   = (state_r != IDLE);
  assign bus.done_o   = done_r;
  assign bus.result_o = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, results, special cases, kill, reset, back-to-back.
module tb_div_unit;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   errors;

  div_unit_if bus ();

  div_unit dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation at the current negedge and follow it to done_o.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    int busy_cnt;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.a_i     = 32'hDEAD_BEEF;
    bus.b_i     = 32'h1234_5678;
    bus.op_i    = 2'b10;
    k        = 0;
    busy_cnt = 0;
    while (bus.done_o !== 1'b1 && k < 60) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      @(negedge clk_i);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " result"}, bus.result_o, exp);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(lat));
    check({tag, " busy low at done"}, {31'd0, bus.busy_o}, 32'd0);
  endtask

  // Directed sequence.
  initial begin
    checks      = 0;
    errors      = 0;
    rst_i       = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.a_i     = 32'h0000_0000;
    bus.b_i     = 32'h0000_0000;
    bus.kill_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset busy", {31'd0, bus.busy_o}, 32'd0);
    check("reset done", {31'd0, bus.done_o}, 32'd0);
    check("reset result", bus.result_o, 32'h0000_0000);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    @(negedge clk_i);
    check("done single pulse", {31'd0, bus.done_o}, 32'd0);
    check("result holds", bus.result_o, 32'd14);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu big", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("remu big", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("div 5/0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("div min/2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

    // Kill during CALC: kill sampled at the 10th iteration edge.
    bus.start_i = 1'b1;
    bus.op_i    = 2'b01;
    bus.a_i     = 32'd1000;
    bus.b_i     = 32'd3;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("busy before kill", {31'd0, bus.busy_o}, 32'd1);
    bus.kill_i = 1'b1;
    @(negedge clk_i);
    bus.kill_i = 1'b0;
    check("kill busy", {31'd0, bus.busy_o}, 32'd0);
    check("kill done", {31'd0, bus.done_o}, 32'd0);
    check("kill result", bus.result_o, 32'hC000_0000);
    run_op("divu 9/3 after kill", 2'b01, 32'd9, 32'd3, 32'd3, 33);

    // Kill together with start in IDLE drops the start.
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.kill_i  = 1'b1;
    bus.op_i    = 2'b00;
    bus.a_i     = 32'd5;
    bus.b_i     = 32'd0;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.kill_i  = 1'b0;
    check("kill+start busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk_i);
    check("kill+start done", {31'd0, bus.done_o}, 32'd0);
    check("kill+start result", bus.result_o, 32'd3);

    // Reset in the middle of CALC.
    bus.start_i = 1'b1;
    bus.op_i    = 2'b01;
    bus.a_i     = 32'd1000;
    bus.b_i     = 32'd3;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid reset busy", {31'd0, bus.busy_o}, 32'd0);
    check("mid reset done", {31'd0, bus.done_o}, 32'd0);
    check("mid reset result", bus.result_o, 32'h0000_0000);
    @(negedge clk_i);

    // Back-to-back: second start lands in the done cycle of the first.
    run_op("b2b divu 1000/10", 2'b01, 32'd1000, 32'd10, 32'd100, 33);
    run_op("b2b divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    @(negedge clk_i);
    check("b2b done single pulse", {31'd0, bus.done_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
